// File: rtl/cpu_bus_lockstep_chk_if.sv
// Bus bundle for the lockstep checker.
// master: drives the control inputs and the reference/DUV transaction
//         streams, and observes the checker status.
// slave : the checker side. It samples the streams and drives the status.
// Handshake: x_vld has no ready. Every cycle in which x_vld is high offers
// exactly one {x_rw, x_addr, x_data} transaction. The checker has no way to
// apply backpressure. A push it cannot store is dropped and ovf_flag reports it.
interface cpu_bus_lockstep_chk_if;
    logic        en;
    logic        clr;
    logic        ref_vld;
    logic [15:0] ref_addr;
    logic [7:0]  ref_data;
    logic        ref_rw;
    logic        duv_vld;
    logic [15:0] duv_addr;
    logic [7:0]  duv_data;
    logic        duv_rw;
    logic [1:0]  state;
    logic [31:0] cmp_cnt;
    logic        mm_flag;
    logic [31:0] mm_idx;
    logic [24:0] mm_ref;
    logic [24:0] mm_duv;
    logic        ovf_flag;
    logic        to_flag;

    modport master (
        output en, clr,
        output ref_vld, ref_addr, ref_data, ref_rw,
        output duv_vld, duv_addr, duv_data, duv_rw,
        input  state, cmp_cnt, mm_flag, mm_idx, mm_ref, mm_duv, ovf_flag, to_flag
    );

    modport slave (
        input  en, clr,
        input  ref_vld, ref_addr, ref_data, ref_rw,
        input  duv_vld, duv_addr, duv_data, duv_rw,
        output state, cmp_cnt, mm_flag, mm_idx, mm_ref, mm_duv, ovf_flag, to_flag
    );
endinterface

// File: rtl/cpu_bus_lockstep_chk.sv
// Lockstep checker for a reference CPU and a DUV CPU that share one clock.
// Each side's bus transactions go into a DEPTH-entry FIFO. The two FIFO
// heads are popped together and compared. The first divergence is latched.
// Overflow and timeout errors are also latched.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : cpu_bus_lockstep_chk_if.slave. It carries en/clr, both transaction
//         streams, the FSM state (0 IDLE, 1 RUN, 2 HALT), cmp_cnt, the
//         first-mismatch record (mm_flag/mm_idx/mm_ref/mm_duv), ovf_flag
//         and to_flag.
module cpu_bus_lockstep_chk #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1024,
    parameter int CMP_RD_DATA = 1,
    parameter int HALT_ON_ERR = 1
) (
    input  logic clk,
    input  logic rst,
    cpu_bus_lockstep_chk_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t      state_q;
    logic [24:0] ref_mem [DEPTH];
    logic [24:0] duv_mem [DEPTH];
    // The extra MSB separates the full case from the empty case.
    logic [AW:0] ref_wp, ref_rp, duv_wp, duv_rp;
    logic [31:0] to_cnt;
    logic [31:0] cmp_cnt_q, mm_idx_q;
    logic [24:0] mm_ref_q, mm_duv_q;
    logic        mm_flag_q, ovf_flag_q, to_flag_q;

    logic        run;
    logic        ref_empty, duv_empty, ref_full, duv_full;
    logic        pop, ref_push, duv_push, ref_ovf, duv_ovf;
    logic [24:0] ref_head, duv_head;
    logic        match, mm_new, ovf_new, to_new, err_new, one_pending;

    always_comb begin
        run       = (state_q == RUN);
        ref_empty = (ref_wp == ref_rp);
        duv_empty = (duv_wp == duv_rp);
        ref_full  = (ref_wp[AW] != ref_rp[AW]) && (ref_wp[AW-1:0] == ref_rp[AW-1:0]);
        duv_full  = (duv_wp[AW] != duv_rp[AW]) && (duv_wp[AW-1:0] == duv_rp[AW-1:0]);
        pop       = run && !ref_empty && !duv_empty;
        ref_head  = ref_mem[ref_rp[AW-1:0]];
        duv_head  = duv_mem[duv_rp[AW-1:0]];
        // A pop on the same edge frees a slot, so a push to a full FIFO still fits.
        ref_push  = run && bus.ref_vld && (!ref_full || pop);
        duv_push  = run && bus.duv_vld && (!duv_full || pop);
        ref_ovf   = run && bus.ref_vld && ref_full && !pop;
        duv_ovf   = run && bus.duv_vld && duv_full && !pop;
        // Read data is a don't-care when CMP_RD_DATA is 0. Bit 24 is rw (1 = read).
        match     = (ref_head[24] == duv_head[24]) &&
                    (ref_head[23:8] == duv_head[23:8]) &&
                    ((ref_head[7:0] == duv_head[7:0]) ||
                     ((CMP_RD_DATA == 0) && ref_head[24]));
        mm_new    = pop && !match;
        ovf_new   = ref_ovf || duv_ovf;
        // Inside RUN, both FIFOs non-empty always means a pop. So this is
        // exactly "one side waiting alone".
        one_pending = run && !pop && (ref_empty != duv_empty);
        to_new    = (TIMEOUT > 0) && one_pending &&
                    (to_cnt + 32'd1 == 32'(TIMEOUT));
        err_new   = mm_new || ovf_new || to_new;
    end

    // Storage has no reset. Resetting the pointers is enough to discard entries.
    always_ff @(posedge clk) begin
        if (ref_push) ref_mem[ref_wp[AW-1:0]] <= {bus.ref_rw, bus.ref_addr, bus.ref_data};
        if (duv_push) duv_mem[duv_wp[AW-1:0]] <= {bus.duv_rw, bus.duv_addr, bus.duv_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ref_wp     <= '0;
            ref_rp     <= '0;
            duv_wp     <= '0;
            duv_rp     <= '0;
            to_cnt     <= '0;
            cmp_cnt_q  <= '0;
            mm_idx_q   <= '0;
            mm_ref_q   <= '0;
            mm_duv_q   <= '0;
            mm_flag_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
            to_flag_q  <= 1'b0;
        end else if (bus.clr) begin
            state_q    <= IDLE;
            ref_wp     <= '0;
            ref_rp     <= '0;
            duv_wp     <= '0;
            duv_rp     <= '0;
            to_cnt     <= '0;
            cmp_cnt_q  <= '0;
            mm_idx_q   <= '0;
            mm_ref_q   <= '0;
            mm_duv_q   <= '0;
            mm_flag_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
            to_flag_q  <= 1'b0;
        end else begin
            if (ref_push) ref_wp <= ref_wp + 1'b1;
            if (duv_push) duv_wp <= duv_wp + 1'b1;
            if (pop) begin
                ref_rp <= ref_rp + 1'b1;
                duv_rp <= duv_rp + 1'b1;
                if (cmp_cnt_q != 32'hFFFF_FFFF) cmp_cnt_q <= cmp_cnt_q + 32'd1;
                if (mm_new && !mm_flag_q) begin
                    mm_flag_q <= 1'b1;
                    mm_idx_q  <= cmp_cnt_q;
                    mm_ref_q  <= ref_head;
                    mm_duv_q  <= duv_head;
                end
            end
            if (ovf_new) ovf_flag_q <= 1'b1;
            if (to_new)  to_flag_q  <= 1'b1;

            // Outside RUN the counter holds.
            if (run) begin
                if (pop || (ref_empty && duv_empty))
                    to_cnt <= '0;
                else if (one_pending && to_cnt != 32'hFFFF_FFFF)
                    to_cnt <= to_cnt + 32'd1;
            end

            case (state_q)
                IDLE: if (bus.en) state_q <= RUN;
                RUN: begin
                    if ((HALT_ON_ERR != 0) && err_new) state_q <= HALT;
                    else if (!bus.en)                  state_q <= IDLE;
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.cmp_cnt  = cmp_cnt_q;
    assign bus.mm_flag  = mm_flag_q;
    assign bus.mm_idx   = mm_idx_q;
    assign bus.mm_ref   = mm_ref_q;
    assign bus.mm_duv   = mm_duv_q;
    assign bus.ovf_flag = ovf_flag_q;
    assign bus.to_flag  = to_flag_q;
endmodule

// File: tb/tb_cpu_bus_lockstep_chk.sv
module tb_cpu_bus_lockstep_chk;
    localparam int DEPTH_A = 8, TO_A = 16, CRD_A = 0, HOE_A = 1;
    localparam int DEPTH_B = 4, TO_B = 24, CRD_B = 1, HOE_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    cpu_bus_lockstep_chk_if bus_a ();
    cpu_bus_lockstep_chk_if bus_b ();

    // Both checkers see the same streams.
    assign bus_b.en       = bus_a.en;
    assign bus_b.clr      = bus_a.clr;
    assign bus_b.ref_vld  = bus_a.ref_vld;
    assign bus_b.ref_addr = bus_a.ref_addr;
    assign bus_b.ref_data = bus_a.ref_data;
    assign bus_b.ref_rw   = bus_a.ref_rw;
    assign bus_b.duv_vld  = bus_a.duv_vld;
    assign bus_b.duv_addr = bus_a.duv_addr;
    assign bus_b.duv_data = bus_a.duv_data;
    assign bus_b.duv_rw   = bus_a.duv_rw;

    cpu_bus_lockstep_chk #(.DEPTH(DEPTH_A), .TIMEOUT(TO_A), .CMP_RD_DATA(CRD_A), .HALT_ON_ERR(HOE_A))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    cpu_bus_lockstep_chk #(.DEPTH(DEPTH_B), .TIMEOUT(TO_B), .CMP_RD_DATA(CRD_B), .HALT_ON_ERR(HOE_B))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model (queues as shifted arrays) ----------------
    logic [1:0]  ms   [2];
    logic [31:0] mcnt [2];
    logic [31:0] midx [2];
    logic [24:0] mref [2];
    logic [24:0] mduv [2];
    bit          mmf  [2];
    bit          movf [2];
    bit          mto  [2];
    int          tc   [2];
    logic [24:0] rq   [2][16];
    logic [24:0] dq   [2][16];
    int          rn   [2];
    int          dn   [2];

    task automatic model_clear(input int m);
        ms[m] = 2'd0; mcnt[m] = 0; midx[m] = 0; mref[m] = 0; mduv[m] = 0;
        mmf[m] = 0; movf[m] = 0; mto[m] = 0; tc[m] = 0; rn[m] = 0; dn[m] = 0;
    endtask

    function automatic bit pair_ok(input logic [24:0] r, input logic [24:0] d, input int crd);
        if (r[24] != d[24] || r[23:8] != d[23:8]) return 0;
        return (r[7:0] == d[7:0]) || (crd == 0 && r[24]);
    endfunction

    task automatic model_step(input int m);
        int d, to, crd, hoe;
        bit r_ne, d_ne, pop, mmn, ovn, ton;
        logic [24:0] re, de;
        d   = (m == 0) ? DEPTH_A : DEPTH_B;
        to  = (m == 0) ? TO_A : TO_B;
        crd = (m == 0) ? CRD_A : CRD_B;
        hoe = (m == 0) ? HOE_A : HOE_B;
        re = {bus_a.ref_rw, bus_a.ref_addr, bus_a.ref_data};
        de = {bus_a.duv_rw, bus_a.duv_addr, bus_a.duv_data};
        if (bus_a.clr) begin model_clear(m); return; end
        if (ms[m] == 2'd0) begin
            if (bus_a.en) ms[m] = 2'd1;
        end else if (ms[m] == 2'd1) begin
            r_ne = rn[m] > 0; d_ne = dn[m] > 0;
            pop = r_ne && d_ne;
            mmn = 0; ovn = 0; ton = 0;
            if (pop) begin
                mmn = !pair_ok(rq[m][0], dq[m][0], crd);
                if (mmn && !mmf[m]) begin
                    mmf[m] = 1; midx[m] = mcnt[m]; mref[m] = rq[m][0]; mduv[m] = dq[m][0];
                end
                if (mcnt[m] != 32'hFFFF_FFFF) mcnt[m] = mcnt[m] + 1;
                for (int i = 0; i < 15; i++) begin rq[m][i] = rq[m][i+1]; dq[m][i] = dq[m][i+1]; end
                rn[m]--; dn[m]--;
            end
            if (pop || (!r_ne && !d_ne)) tc[m] = 0;
            else begin
                tc[m]++;
                if (to > 0 && tc[m] == to) ton = 1;
            end
            if (bus_a.ref_vld) begin
                if (rn[m] < d) begin rq[m][rn[m]] = re; rn[m]++; end else ovn = 1;
            end
            if (bus_a.duv_vld) begin
                if (dn[m] < d) begin dq[m][dn[m]] = de; dn[m]++; end else ovn = 1;
            end
            if (ovn) movf[m] = 1;
            if (ton) mto[m] = 1;
            if (hoe != 0 && (mmn || ovn || ton)) ms[m] = 2'd2;
            else if (!bus_a.en) ms[m] = 2'd0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("a.state",   32'(bus_a.state),    32'(ms[0]));
        chk("a.cmp_cnt", bus_a.cmp_cnt,       mcnt[0]);
        chk("a.mm_flag", 32'(bus_a.mm_flag),  32'(mmf[0]));
        chk("a.mm_idx",  bus_a.mm_idx,        midx[0]);
        chk("a.mm_ref",  32'(bus_a.mm_ref),   32'(mref[0]));
        chk("a.mm_duv",  32'(bus_a.mm_duv),   32'(mduv[0]));
        chk("a.ovf",     32'(bus_a.ovf_flag), 32'(movf[0]));
        chk("a.to",      32'(bus_a.to_flag),  32'(mto[0]));
        chk("b.state",   32'(bus_b.state),    32'(ms[1]));
        chk("b.cmp_cnt", bus_b.cmp_cnt,       mcnt[1]);
        chk("b.mm_flag", 32'(bus_b.mm_flag),  32'(mmf[1]));
        chk("b.mm_idx",  bus_b.mm_idx,        midx[1]);
        chk("b.mm_ref",  32'(bus_b.mm_ref),   32'(mref[1]));
        chk("b.mm_duv",  32'(bus_b.mm_duv),   32'(mduv[1]));
        chk("b.ovf",     32'(bus_b.ovf_flag), 32'(movf[1]));
        chk("b.to",      32'(bus_b.to_flag),  32'(mto[1]));
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, ".state"},   32'(bus_a.state),    32'd0);
        chk({tag, ".cmp_cnt"}, bus_a.cmp_cnt,       32'd0);
        chk({tag, ".mm_flag"}, 32'(bus_a.mm_flag),  32'd0);
        chk({tag, ".mm_idx"},  bus_a.mm_idx,        32'd0);
        chk({tag, ".mm_ref"},  32'(bus_a.mm_ref),   32'd0);
        chk({tag, ".mm_duv"},  32'(bus_a.mm_duv),   32'd0);
        chk({tag, ".ovf"},     32'(bus_a.ovf_flag), 32'd0);
        chk({tag, ".to"},      32'(bus_a.to_flag),  32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic clr, input logic rv, input logic [24:0] re,
                         input logic dv, input logic [24:0] de);
        bus_a.en = en; bus_a.clr = clr;
        bus_a.ref_vld = rv; {bus_a.ref_rw, bus_a.ref_addr, bus_a.ref_data} = re;
        bus_a.duv_vld = dv; {bus_a.duv_rw, bus_a.duv_addr, bus_a.duv_data} = de;
    endtask

    // One clock: the model steps on the edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin model_clear(0); model_clear(1); end
        else begin model_step(0); model_step(1); end
        @(negedge clk);
        chk_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en, clr, rv;
        logic [24:0] re;
        logic        dv;
        logic [24:0] de;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        mm;
        logic [31:0] idx;
        logic        ovf;
    } vec_t;

    vec_t tbl [10];
    logic [24:0] pend_q [$];
    logic [24:0] e, ed;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_clear(0); model_clear(1);
        #12;
        chk_zero_a("reset");
        @(negedge clk); rst = 1'b0;
        cycle();
        chk_zero_a("idle");

        //             en clr rv re           dv de           st    cnt mm idx ovf
        tbl[0] = '{1'b1, 1'b0, 1'b0, 25'h0,       1'b0, 25'h0,       2'd1, 0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 25'h0FFFC4C, 1'b1, 25'h0FFFC4C, 2'd1, 0, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 25'h18000A9, 1'b1, 25'h18000A9, 2'd1, 1, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 25'h0,       1'b0, 25'h0,       2'd1, 2, 1'b0, 0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 25'h1123411, 1'b1, 25'h1123422, 2'd1, 2, 1'b0, 0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 25'h0,       1'b0, 25'h0,       2'd1, 3, 1'b0, 0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 25'h000A020, 1'b1, 25'h000A021, 2'd1, 3, 1'b0, 0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 25'h0,       1'b0, 25'h0,       2'd2, 4, 1'b1, 3, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 25'h0FFFC4C, 1'b1, 25'h0FFFC4C, 2'd2, 4, 1'b1, 3, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 25'h0,       1'b0, 25'h0,       2'd0, 0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].rv, tbl[i].re, tbl[i].dv, tbl[i].de);
            cycle();
            chk($sformatf("tbl%0d.state", i), 32'(bus_a.state),   32'(tbl[i].st));
            chk($sformatf("tbl%0d.cnt", i),   bus_a.cmp_cnt,      tbl[i].cnt);
            chk($sformatf("tbl%0d.mm", i),    32'(bus_a.mm_flag), 32'(tbl[i].mm));
            chk($sformatf("tbl%0d.idx", i),   bus_a.mm_idx,       tbl[i].idx);
            chk($sformatf("tbl%0d.ovf", i),   32'(bus_a.ovf_flag), 32'(tbl[i].ovf));
        end

        // Data mismatch on the third pair of a write stream.
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 25'h0001001, 1, 25'h0001001); cycle();
        drive(1, 0, 1, 25'h1002002, 1, 25'h1002002); cycle();
        drive(1, 0, 1, 25'h0004020, 1, 25'h0004021); cycle();
        drive(1, 0, 0, 0, 0, 0); cycle();
        chk("mm.state",  32'(bus_a.state),   32'd2);
        chk("mm.flag",   32'(bus_a.mm_flag), 32'd1);
        chk("mm.idx",    bus_a.mm_idx,       32'd2);
        chk("mm.ref",    32'(bus_a.mm_ref),  32'h0004020);
        chk("mm.duv",    32'(bus_a.mm_duv),  32'h0004021);
        drive(1, 0, 1, 25'h0001001, 1, 25'h0001001); cycle();
        drive(1, 0, 0, 0, 0, 0); cycle();
        chk("mm.halted_cnt", bus_a.cmp_cnt, 32'd3);
        drive(0, 1, 0, 0, 0, 0); cycle();

        // Skew: DUV replays the same five entries six cycles late.
        drive(1, 0, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 11; i++) begin
            e  = {1'(i), 16'(16'h0100 + i), 8'(8'h30 + i)};
            ed = {1'(i - 6), 16'(16'h0100 + i - 6), 8'(8'h30 + i - 6)};
            drive(1, 0, i < 5, e, i >= 6, ed);
            cycle();
        end
        drive(1, 0, 0, 0, 0, 0); cycle();
        chk("skew.cnt",   bus_a.cmp_cnt,      32'd5);
        chk("skew.mm",    32'(bus_a.mm_flag), 32'd0);
        chk("skew.to",    32'(bus_a.to_flag), 32'd0);
        chk("skew.state", 32'(bus_a.state),   32'd1);
        drive(0, 1, 0, 0, 0, 0); cycle();

        // Overflow: DEPTH+1 reference pushes and no DUV pushes.
        drive(1, 0, 0, 0, 0, 0); cycle();
        for (int i = 0; i <= DEPTH_A; i++) begin
            drive(1, 0, 1, 25'(32'h0050000 + i), 0, 0);
            cycle();
            if (i == DEPTH_A - 1) begin
                chk("ovf.before", 32'(bus_a.ovf_flag), 32'd0);
                chk("ovf.run",    32'(bus_a.state),    32'd1);
            end
        end
        chk("ovf.flag", 32'(bus_a.ovf_flag), 32'd1);
        chk("ovf.halt", 32'(bus_a.state),    32'd2);
        drive(0, 1, 0, 0, 0, 0); cycle();
        chk_zero_a("clr");

        // Timeout: one lone reference push.
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 25'h1ABCD77, 0, 0); cycle();
        for (int i = 1; i <= TO_A; i++) begin
            drive(1, 0, 0, 0, 0, 0); cycle();
            if (i == TO_A - 1) chk("to.before", 32'(bus_a.to_flag), 32'd0);
        end
        chk("to.flag", 32'(bus_a.to_flag), 32'd1);
        chk("to.halt", 32'(bus_a.state),   32'd2);
        drive(0, 1, 0, 0, 0, 0); cycle();

        // Asynchronous reset with entries buffered.
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 25'h0000011, 1, 25'h0000011); cycle();
        drive(1, 0, 1, 25'h0000022, 0, 0); cycle();
        rst = 1'b1;
        #1;
        chk_zero_a("arst");
        chk("arst.b_cnt", bus_b.cmp_cnt, 32'd0);
        drive(1, 0, 0, 0, 0, 0); cycle();
        rst = 1'b0;
        cycle();
        drive(1, 0, 0, 0, 1, 25'h0000022); cycle();
        drive(1, 0, 0, 0, 0, 0); cycle();
        chk("arst.flushed", bus_a.cmp_cnt, 32'd0);

        // Random streams: DUV replays the reference stream with jitter and rare corruption.
        drive(0, 1, 0, 0, 0, 0); cycle();
        for (int c = 0; c < 1500; c++) begin
            logic en_r, clr_r, rv, dv;
            logic [24:0] re, de;
            en_r  = ($urandom_range(0, 39) != 0);
            clr_r = ($urandom_range(0, 99) == 0);
            rv    = ($urandom_range(0, 2) == 0);
            re    = 25'($urandom());
            if (rv) pend_q.push_back(re);
            dv = 1'b0; de = 25'($urandom());
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 0) begin
                dv = 1'b1;
                de = pend_q.pop_front();
                if ($urandom_range(0, 15) == 0) de = de ^ (25'd1 << $urandom_range(0, 24));
            end
            if ($urandom_range(0, 199) == 0) begin dv = 1'b1; de = 25'($urandom()); end
            if (clr_r) pend_q.delete();
            drive(en_r, clr_r, rv, re, dv, de);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_bus_lockstep_chk.md
Name: cpu_bus_lockstep_chk

Overview:
Lockstep checker that consumes the CPU bus transactions produced by the reference-model CPU and the design-under-verification CPU, which run side by side on one clock. Each side's transactions are buffered in a small FIFO so the two CPUs may drift by up to DEPTH transactions. Head entries are compared in order and the first divergence is latched together with overflow and timeout errors. The block is synthesizable so it can also sit on-chip next to the CPU pair.

Parameters:
DEPTH, 8, entries per side FIFO; power of two, at least 2
TIMEOUT, 1024, cycles one side may be pending alone before to_flag is set; 0 disables the timeout
CMP_RD_DATA, 1, 1 compares data on reads and writes; 0 compares data on writes only
HALT_ON_ERR, 1, 1 moves the FSM to HALT on the first error; 0 keeps checking

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  enables checking
clr  in  1  synchronous clear of FIFOs, counters, flags and FSM
ref_vld  in  1  one reference-side bus transaction this cycle
ref_addr  in  16  reference address
ref_data  in  8  reference data
ref_rw  in  1  reference direction, 1 = read
duv_vld / duv_addr / duv_data / duv_rw  in  1/16/8/1  same as above for the DUV side
state  out  2  0 IDLE, 1 RUN, 2 HALT
cmp_cnt  out  32  number of compared pairs; saturates at 0xFFFF_FFFF
mm_flag  out  1  sticky: a mismatch has been detected
mm_idx  out  32  cmp_cnt value at the first mismatch (0-based pair index)
mm_ref  out  25  {rw, addr, data} of the reference entry at the first mismatch
mm_duv  out  25  {rw, addr, data} of the DUV entry at the first mismatch
ovf_flag  out  1  sticky: a push into a full FIFO
to_flag  out  1  sticky: timeout reached

Behaviour:
- Reset: all outputs 0, both FIFOs empty, timeout counter 0, state IDLE. Reset asserted mid-operation aborts immediately and discards buffered entries.
- Priority order: rst, then clr, then normal operation. clr forces the same values as reset on the next edge.
- FSM:
  - IDLE: en=1 moves to RUN.
  - RUN: en=0 moves to IDLE; FIFO contents are retained. Any new error with HALT_ON_ERR=1 moves to HALT.
  - HALT: leaves only on clr, which returns to IDLE.
- Push: only in RUN. An x_vld sampled at edge t writes the entry into the x FIFO. In IDLE and HALT, vld is ignored.
- Pop and compare: in RUN with both FIFOs non-empty, both heads pop at the same edge. The comparison is combinational on the heads and its results are registered at the pop edge.
  - Latency: if both sides push at edge t, cmp_cnt and mm_* update at edge t+1.
- Match rule: rw equal AND addr equal AND (data equal OR (CMP_RD_DATA=0 AND rw=1)).
- First mismatch: on the first mismatching pop, mm_flag=1, mm_idx is the pre-increment cmp_cnt, and mm_ref/mm_duv capture the two heads. Later mismatches do not update mm_*.
- cmp_cnt increments on every pop, whether the pair matches or not.
- Full: a push to a full FIFO with no simultaneous pop of that FIFO drops the entry and sets ovf_flag. A push and a pop in the same cycle on a full FIFO are both accepted.
- Empty: no pop happens while either FIFO is empty. There is no underflow path.
- Pointers wrap modulo DEPTH; full and empty are distinguished with an extra pointer bit.
- Timeout counter:
  - Increments each RUN cycle in which exactly one FIFO is non-empty and no pop occurs.
  - Clears to 0 on a pop or when both FIFOs are empty.
  - Holds its value outside RUN.
  - When it equals TIMEOUT (TIMEOUT>0), to_flag is set at that edge.
- Errors: mismatch, overflow and timeout are each sticky until rst or clr. When more than one occurs on the same edge, all are flagged and the transition to HALT happens once.

Test Plan:
- Equal streams: both sides push {0,FFFC,4C},{1,8000,A9} on the same cycles -> cmp_cnt=2 at the edge after the second push; mm_flag=0; state=RUN.
- Skew: ref pushes 5 entries; duv pushes the same 5 entries 6 cycles later -> no error; cmp_cnt=5 one cycle after the last duv push.
- Data mismatch: third pair has ref data 0x20 and duv data 0x21 on a write -> mm_flag=1, mm_idx=2, mm_ref={0,addr,20}, mm_duv={0,addr,21}, state=HALT; further pushes are ignored.
- Read-data mask: CMP_RD_DATA=0, read pair differing only in data -> no mismatch. The same pair as a write -> mismatch.
- Overflow: ref pushes DEPTH+1 entries with no duv pushes -> ovf_flag=1 on the DEPTH+1th push and HALT. Then clr -> all outputs 0, state IDLE.
- Timeout and reset: TIMEOUT=16, one ref push only -> to_flag=1 exactly 16 RUN cycles later. Asserting rst mid-stream -> all outputs 0 asynchronously.
